// File: rtl/dac_spi_update.sv
// SPI write controller for a dual-setpoint DAC: each accepted trigger sends one
// 24-bit {CMD, data} frame, then pulses LDAC, then enforces an idle gap.
module dac_spi_update #(
  parameter int          SCLK_DIV = 4,
  parameter int          LDAC_W   = 4,
  parameter int          CS_GAP   = 4,
  parameter logic [3:0]  CMD      = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_pulse,
  input  logic        enable,
  input  logic [19:0] set_a,
  input  logic [19:0] set_b,
  output logic        dac_sclk,
  output logic        dac_cs_n,
  output logic        dac_sdo,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_LDAC, S_GAP
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] LDAC_LAST = 16'(LDAC_W - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shreg_q, shreg_d;
  logic        sel_q, sel_d;
  logic        pending_q, pending_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ovr_d;
  logic        start_s;
  logic        shifting_s;
  logic        sclk_q, cs_n_q, sdo_q, ldac_n_q, busy_q, overrun_q;

  assign start_s    = (trig_pulse | pending_q) & enable;
  assign shifting_s = (state_q == S_SETUP) || (state_q == S_SHIFT_HI) || (state_q == S_SHIFT_LO);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    sel_d       = sel_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start_s) begin
          state_d = S_SETUP;
          shreg_d = {CMD, (sel_q ? set_b : set_a)};
          sel_d   = ~sel_q;
          bit_d   = 5'd23;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT_HI;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT_LO;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 16'd0;
          if (bit_q == 5'd0) begin
            state_d = S_LDAC;
          end else begin
            // Shift lands together with the HI entry, so sdo moves only on the rising sclk.
            state_d = S_SHIFT_HI;
            bit_d   = bit_q - 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
          end
        end else begin
          state_d = S_SHIFT_LO;
        end
      end
      S_LDAC: begin
        if (cnt_q == 16'd0) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
        if (cnt_q == LDAC_LAST) begin
          state_d = S_GAP;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_LDAC;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // One trigger may queue behind a busy frame; a second one is dropped.
    if (!enable) begin
      pending_d = 1'b0;
      sel_d     = 1'b0;
    end else if (trig_pulse && (state_q != S_IDLE)) begin
      if (pending_q) begin
        ovr_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if ((state_q == S_IDLE) && start_s) begin
      pending_d = trig_pulse & pending_q;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_q       <= 5'd0;
      shreg_q     <= 24'd0;
      sel_q       <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdo_q       <= 1'b0;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      sclk_q      <= (state_q == S_SHIFT_HI);
      cs_n_q      <= ~shifting_s;
      sdo_q       <= shifting_s & shreg_q[23];
      ldac_n_q    <= (state_q != S_LDAC);
      busy_q      <= (state_q != S_IDLE);
      overrun_q   <= ovr_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sdo    = sdo_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_update.sv
// Directed bench for dac_spi_update: a negedge monitor decodes SPI frames and
// pulse widths into queues that the test sequences compare against constants.
module tb_dac_spi_update;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig_pulse = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] set_a = 20'd0;
  logic [19:0] set_b = 20'd0;
  logic        dac_sclk, dac_cs_n, dac_sdo, dac_ldac_n, busy, overrun;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dac_spi_update dut (
    .clk(clk), .reset(reset), .trig_pulse(trig_pulse), .enable(enable),
    .set_a(set_a), .set_b(set_b), .dac_sclk(dac_sclk), .dac_cs_n(dac_cs_n),
    .dac_sdo(dac_sdo), .dac_ldac_n(dac_ldac_n), .busy(busy),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int frames[$], nbits_q[$], cslen_q[$], first_q[$], ldac_q[$], busylen_q[$], gap_q[$];
  int ovr_cnt = 0;

  // Monitor: DAC captures sdo on each falling sclk while cs_n is low.
  initial begin
    logic [23:0] word;
    int nb, cs_cnt, first, ld_cnt, b_cnt, idle_cnt;
    logic prev_sclk, prev_cs, prev_ldac, prev_busy;
    word = 24'd0; nb = 0; cs_cnt = 0; first = -1; ld_cnt = 0; b_cnt = 0; idle_cnt = 0;
    prev_sclk = 1'b0; prev_cs = 1'b1; prev_ldac = 1'b1; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        word = 24'd0; nb = 0; cs_cnt = 0; first = -1; ld_cnt = 0; b_cnt = 0; idle_cnt = 0;
        prev_sclk = 1'b0; prev_cs = 1'b1; prev_ldac = 1'b1; prev_busy = 1'b0;
      end else begin
        if (!dac_cs_n) begin
          if (dac_sclk && !prev_sclk && nb == 0 && first < 0) first = cs_cnt;
          if (!dac_sclk && prev_sclk) begin
            word = {word[22:0], dac_sdo};
            nb++;
          end
          cs_cnt++;
        end else if (!prev_cs) begin
          frames.push_back(int'(word)); nbits_q.push_back(nb);
          cslen_q.push_back(cs_cnt); first_q.push_back(first);
          word = 24'd0; nb = 0; cs_cnt = 0; first = -1;
        end
        if (!dac_ldac_n) ld_cnt++;
        else if (!prev_ldac) begin ldac_q.push_back(ld_cnt); ld_cnt = 0; end
        if (busy) begin
          if (!prev_busy) gap_q.push_back(idle_cnt);
          b_cnt++; idle_cnt = 0;
        end else begin
          if (prev_busy) begin busylen_q.push_back(b_cnt); b_cnt = 0; end
          idle_cnt++;
        end
        if (overrun) ovr_cnt++;
        prev_sclk = dac_sclk; prev_cs = dac_cs_n; prev_ldac = dac_ldac_n; prev_busy = busy;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clr();
    frames.delete(); nbits_q.delete(); cslen_q.delete(); first_q.delete();
    ldac_q.delete(); busylen_q.delete(); gap_q.delete(); ovr_cnt = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; trig_pulse = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse();
    @(negedge clk) trig_pulse = 1'b1;
    @(negedge clk) trig_pulse = 1'b0;
  endtask

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic [23:0] wa;
    logic [23:0] wb;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{20'h12345, 20'hABCDE, 24'h112345, 24'h1ABCDE};
    vecs[1] = '{20'hAAAAA, 20'h55555, 24'h1AAAAA, 24'h155555};
    vecs[2] = '{20'h00000, 20'hFFFFF, 24'h100000, 24'h1FFFFF};
    vecs[3] = '{20'h80001, 20'h7FFFE, 24'h180001, 24'h17FFFE};

    // Reset state
    do_reset();
    chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
    chk("rst_sclk", 32'(dac_sclk), 32'd0);
    chk("rst_sdo", 32'(dac_sdo), 32'd0);
    chk("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Single frame with latency checks
    enable = 1'b1; set_a = 20'h12345; set_b = 20'h00000;
    clr();
    pulse();
    chk("lat_cs_still_high", 32'(dac_cs_n), 32'd1);
    @(negedge clk);
    chk("lat_cs_low", 32'(dac_cs_n), 32'd0);
    chk("lat_busy_high", 32'(busy), 32'd1);
    wait_cyc(300);
    chk("single_nframes", 32'(frames.size()), 32'd1);
    chk("single_word", 32'(at(frames, 0)), 32'h112345);
    chk("single_nbits", 32'(at(nbits_q, 0)), 32'd24);
    chk("single_cs_len", 32'(at(cslen_q, 0)), 32'd196);
    chk("single_first_rise", 32'(at(first_q, 0)), 32'd4);
    chk("single_ldac_len", 32'(at(ldac_q, 0)), 32'd4);
    chk("single_busy_len", 32'(at(busylen_q, 0)), 32'd204);
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);

    // Table: A then B frames for several data patterns
    for (int i = 0; i < 4; i++) begin
      do_reset();
      clr();
      set_a = vecs[i].a; set_b = vecs[i].b; enable = 1'b1;
      pulse(); wait_cyc(298);
      pulse(); wait_cyc(298);
      chk($sformatf("vec%0d_nframes", i), 32'(frames.size()), 32'd2);
      chk($sformatf("vec%0d_word_a", i), 32'(at(frames, 0)), 32'(vecs[i].wa));
      chk($sformatf("vec%0d_word_b", i), 32'(at(frames, 1)), 32'(vecs[i].wb));
      chk($sformatf("vec%0d_nbits", i), 32'(at(nbits_q, 1)), 32'd24);
      chk($sformatf("vec%0d_cs_len", i), 32'(at(cslen_q, 1)), 32'd196);
      chk($sformatf("vec%0d_ldac_len", i), 32'(at(ldac_q, 1)), 32'd4);
      chk($sformatf("vec%0d_busy_len", i), 32'(at(busylen_q, 1)), 32'd204);
      chk($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'd2);
    end

    // Alternation A,B,A,B
    do_reset();
    clr();
    set_a = 20'hAAAAA; set_b = 20'h55555;
    for (int k = 0; k < 4; k++) begin
      pulse(); wait_cyc(298);
    end
    chk("alt_nframes", 32'(frames.size()), 32'd4);
    chk("alt_f0", 32'(at(frames, 0)), 32'h1AAAAA);
    chk("alt_f1", 32'(at(frames, 1)), 32'h155555);
    chk("alt_f2", 32'(at(frames, 2)), 32'h1AAAAA);
    chk("alt_f3", 32'(at(frames, 3)), 32'h155555);
    chk("alt_frame_cnt", 32'(frame_cnt), 32'd4);

    // Enable dropped mid-frame: frame completes, trigger ignored, sel back to A
    clr();
    set_a = 20'h13579; set_b = 20'h2468A;
    pulse(); wait_cyc(50);
    enable = 1'b0; wait_cyc(10);
    pulse(); wait_cyc(300);
    chk("en_nframes", 32'(frames.size()), 32'd1);
    chk("en_word", 32'(at(frames, 0)), 32'h113579);
    chk("en_overrun", 32'(ovr_cnt), 32'd0);
    enable = 1'b1;
    pulse(); wait_cyc(300);
    chk("en_reenable_nframes", 32'(frames.size()), 32'd2);
    chk("en_reenable_word", 32'(at(frames, 1)), 32'h113579);
    chk("en_frame_cnt", 32'(frame_cnt), 32'd6);

    // Reset during bit 10 of a frame
    pulse(); wait_cyc(110);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(dac_cs_n), 32'd1);
    chk("midrst_sclk", 32'(dac_sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_ldac_n", 32'(dac_ldac_n), 32'd1);
    reset = 1'b0;
    wait_cyc(2);

    // Pending: second trigger queued, starts after one idle cycle
    do_reset();
    clr();
    set_a = 20'hAAAAA; set_b = 20'h55555;
    pulse(); wait_cyc(98);
    pulse(); wait_cyc(500);
    chk("pend_nframes", 32'(frames.size()), 32'd2);
    chk("pend_f0", 32'(at(frames, 0)), 32'h1AAAAA);
    chk("pend_f1", 32'(at(frames, 1)), 32'h155555);
    chk("pend_overrun", 32'(ovr_cnt), 32'd0);
    chk("pend_idle_gap", 32'(at(gap_q, 1)), 32'd1);
    chk("pend_busy_len", 32'(at(busylen_q, 1)), 32'd204);

    // Overrun: third trigger while one is already pending
    do_reset();
    clr();
    pulse(); wait_cyc(48);
    pulse(); wait_cyc(48);
    pulse(); wait_cyc(500);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    chk("ovr_nframes", 32'(frames.size()), 32'd2);
    chk("ovr_f0", 32'(at(frames, 0)), 32'h1AAAAA);
    chk("ovr_f1", 32'(at(frames, 1)), 32'h155555);
    pulse(); wait_cyc(300);
    chk("ovr_next_nframes", 32'(frames.size()), 32'd3);
    chk("ovr_next_word", 32'(at(frames, 2)), 32'h1AAAAA);

    // Frame counter wrap
    do_reset();
    @(negedge clk) force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk) release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    pulse(); wait_cyc(300);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
